// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard controller. Detects hazards that forwarding cannot
//   cover (load-use, branch operands needed in ID, data-memory waits) and
//   generates hold / flush / bubble controls for the PC and pipeline
//   registers. Also keeps saturating performance counters.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   rs1_ID, rs2_ID      ID source registers
//   use_rs1_ID/rs2_ID   ID instruction actually reads rs1 / rs2
//   is_branch_ID        ID instruction is a branch/JALR (operands used in ID)
//   branch_taken_ID     ID branch/jump redirects the PC
//   rd_EX, MemRead_EX   EX destination / EX is a load
//   rd_MEM, MemRead_MEM MEM destination / MEM is a load
//   dmem_req_MEM        MEM has an outstanding data access
//   dmem_ready          data memory completes the access this cycle
//   pc_hold .. memwb_bubble  pipeline control outputs (combinational)
//   stall_cycles        data-hazard stall cycles (saturating)
//   flush_count         taken-branch flushes (saturating)
//   memwait_cycles      memory freeze cycles (saturating)

module hazard_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             use_rs1_ID,
    input  logic             use_rs2_ID,
    input  logic             is_branch_ID,
    input  logic             branch_taken_ID,
    input  logic [4:0]       rd_EX,
    input  logic             MemRead_EX,
    input  logic [4:0]       rd_MEM,
    input  logic             MemRead_MEM,
    input  logic             dmem_req_MEM,
    input  logic             dmem_ready,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_hold,
    output logic             idex_flush,
    output logic             exmem_hold,
    output logic             memwb_bubble,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] memwait_cycles
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_STALL   = 2'd1,
        S_MEMWAIT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    state_t           resume_q, resume_d;
    state_t           eff_state;
    logic [1:0]       stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, flush_count_q, memwait_cycles_q;

    logic       match_ex, match_mem;
    logic [1:0] need;
    logic       busy;
    logic       freeze, stall, flush;

    // Register 0 is never a real producer.
    assign match_ex  = (rd_EX != 5'd0) &&
                       ((use_rs1_ID && (rd_EX == rs1_ID)) ||
                        (use_rs2_ID && (rd_EX == rs2_ID)));
    assign match_mem = (rd_MEM != 5'd0) &&
                       ((use_rs1_ID && (rd_MEM == rs1_ID)) ||
                        (use_rs2_ID && (rd_MEM == rs2_ID)));

    // Only loads stall; ALU results are covered by forwarding. A branch
    // needs the value in ID, so a load in EX costs it two cycles and a
    // load in MEM one.
    always_comb begin
        need = 2'd0;
        if (MemRead_EX && match_ex) begin
            need = is_branch_ID ? 2'd2 : 2'd1;
        end else if (is_branch_ID && MemRead_MEM && match_mem) begin
            need = 2'd1;
        end
    end

    assign busy = dmem_req_MEM && !dmem_ready;

    // Once the wait ends, the cycle behaves as the interrupted state.
    assign eff_state = (state_q == S_MEMWAIT) ? resume_q : state_q;

    always_comb begin
        state_d     = state_q;
        resume_d    = resume_q;
        stall_cnt_d = stall_cnt_q;
        freeze      = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;

        if (busy) begin
            freeze = 1'b1;
            if (state_q != S_MEMWAIT) begin
                state_d  = S_MEMWAIT;
                resume_d = state_q;
            end
        end else begin
            state_d = eff_state;
            case (eff_state)
                S_RUN: begin
                    if (need != 2'd0) begin
                        stall = 1'b1;
                        if (need == 2'd2) begin
                            state_d     = S_STALL;
                            stall_cnt_d = 2'd1;
                        end
                    end else if (branch_taken_ID) begin
                        flush = 1'b1;
                    end
                end
                S_STALL: begin
                    stall       = 1'b1;
                    stall_cnt_d = stall_cnt_q - 2'd1;
                    if (stall_cnt_q == 2'd1) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                    state_d = S_RUN;
                end
            endcase
        end
    end

    assign pc_hold      = freeze | stall;
    assign ifid_hold    = freeze | stall;
    assign ifid_flush   = flush;
    assign idex_hold    = freeze;
    assign idex_flush   = stall;
    assign exmem_hold   = freeze;
    assign memwb_bubble = freeze;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_RUN;
            resume_q         <= S_RUN;
            stall_cnt_q      <= '0;
            stall_cycles_q   <= '0;
            flush_count_q    <= '0;
            memwait_cycles_q <= '0;
        end else begin
            state_q     <= state_d;
            resume_q    <= resume_d;
            stall_cnt_q <= stall_cnt_d;
            if (stall && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + 1'b1;
            end
            if (flush && (flush_count_q != '1)) begin
                flush_count_q <= flush_count_q + 1'b1;
            end
            if (freeze && (memwait_cycles_q != '1)) begin
                memwait_cycles_q <= memwait_cycles_q + 1'b1;
            end
        end
    end

    assign stall_cycles   = stall_cycles_q;
    assign flush_count    = flush_count_q;
    assign memwait_cycles = memwait_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    rs1_ID, rs2_ID, rd_EX, rd_MEM;
    logic          use_rs1_ID, use_rs2_ID, is_branch_ID, branch_taken_ID;
    logic          MemRead_EX, MemRead_MEM, dmem_req_MEM, dmem_ready;
    logic          pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush;
    logic          exmem_hold, memwb_bubble;
    logic [CW-1:0] stall_cycles, flush_count, memwait_cycles;

    int total = 0;
    int bad   = 0;

    // {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold, memwb_bubble}
    localparam logic [6:0] C_NONE   = 7'b0000000;
    localparam logic [6:0] C_STALL  = 7'b1100100;
    localparam logic [6:0] C_FREEZE = 7'b1101011;
    localparam logic [6:0] C_FLUSH  = 7'b0010000;

    logic [6:0] ctrl;
    assign ctrl = {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush,
                   exmem_hold, memwb_bubble};

    hazard_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
        .is_branch_ID(is_branch_ID), .branch_taken_ID(branch_taken_ID),
        .rd_EX(rd_EX), .MemRead_EX(MemRead_EX),
        .rd_MEM(rd_MEM), .MemRead_MEM(MemRead_MEM),
        .dmem_req_MEM(dmem_req_MEM), .dmem_ready(dmem_ready),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
        .idex_hold(idex_hold), .idex_flush(idex_flush),
        .exmem_hold(exmem_hold), .memwb_bubble(memwb_bubble),
        .stall_cycles(stall_cycles), .flush_count(flush_count),
        .memwait_cycles(memwait_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        rs1_ID = '0; rs2_ID = '0; rd_EX = '0; rd_MEM = '0;
        use_rs1_ID = 1'b0; use_rs2_ID = 1'b0;
        is_branch_ID = 1'b0; branch_taken_ID = 1'b0;
        MemRead_EX = 1'b0; MemRead_MEM = 1'b0;
        dmem_req_MEM = 1'b0; dmem_ready = 1'b0;
    endtask

    // Inputs change at the negedge; outputs are sampled 1 time unit later.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic counters(input string tag, input int s, input int f, input int m);
        chk({tag, "_stall_cycles"}, 32'(stall_cycles), 32'(s));
        chk({tag, "_flush_count"}, 32'(flush_count), 32'(f));
        chk({tag, "_memwait_cycles"}, 32'(memwait_cycles), 32'(m));
    endtask

    // Branch (beq using rs2=7) sitting in ID behind a load of x7 in EX.
    task automatic branch_after_load();
        clr();
        rd_EX = 5'd7; MemRead_EX = 1'b1;
        rs2_ID = 5'd7; use_rs2_ID = 1'b1;
        rs1_ID = 5'd1; use_rs1_ID = 1'b1;
        is_branch_ID = 1'b1; branch_taken_ID = 1'b1;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        #1;
        chk("reset_ctrl", 32'(ctrl), 32'(C_NONE));
        counters("reset", 0, 0, 0);
        cyc();
        rst = 1'b0;

        // ALU load-use: exactly one stall cycle
        cyc();
        clr();
        rd_EX = 5'd5; MemRead_EX = 1'b1; rs1_ID = 5'd5; use_rs1_ID = 1'b1;
        #1 chk("lu_stall", 32'(ctrl), 32'(C_STALL));
        cyc();
        MemRead_EX = 1'b0; rd_EX = 5'd0; MemRead_MEM = 1'b1; rd_MEM = 5'd5;
        #1 chk("lu_after", 32'(ctrl), 32'(C_NONE));
        counters("lu", 1, 0, 0);

        // Branch after load: two stalls, then the flush
        do_reset();
        branch_after_load();
        #1 chk("bl_stall1", 32'(ctrl), 32'(C_STALL));
        cyc();
        MemRead_EX = 1'b0; rd_EX = 5'd0; MemRead_MEM = 1'b1; rd_MEM = 5'd7;
        #1 chk("bl_stall2", 32'(ctrl), 32'(C_STALL));
        cyc();
        MemRead_MEM = 1'b0; rd_MEM = 5'd0;
        #1 chk("bl_flush", 32'(ctrl), 32'(C_FLUSH));
        cyc();
        clr();
        #1 chk("bl_idle", 32'(ctrl), 32'(C_NONE));
        counters("bl", 2, 1, 0);

        // x0 destination and unused source never stall; ALU producer neither
        do_reset();
        rd_EX = 5'd0; MemRead_EX = 1'b1; rs1_ID = 5'd0; use_rs1_ID = 1'b1;
        #1 chk("x0_nostall", 32'(ctrl), 32'(C_NONE));
        cyc();
        clr();
        rd_EX = 5'd3; MemRead_EX = 1'b1; rs1_ID = 5'd3; use_rs1_ID = 1'b0;
        #1 chk("nouse_nostall", 32'(ctrl), 32'(C_NONE));
        cyc();
        clr();
        rd_EX = 5'd3; rs1_ID = 5'd3; use_rs1_ID = 1'b1; is_branch_ID = 1'b1;
        #1 chk("alu_nostall", 32'(ctrl), 32'(C_NONE));
        cyc();
        // Branch with a load in MEM: single stall
        clr();
        rd_MEM = 5'd9; MemRead_MEM = 1'b1; rs1_ID = 5'd9; use_rs1_ID = 1'b1;
        is_branch_ID = 1'b1;
        #1 chk("mem_load_br_stall", 32'(ctrl), 32'(C_STALL));
        cyc();
        clr();
        #1 chk("mem_load_br_done", 32'(ctrl), 32'(C_NONE));
        counters("x0", 1, 0, 0);

        // Memory wait inside the two-cycle stall
        do_reset();
        branch_after_load();
        #1 chk("mw_stall1", 32'(ctrl), 32'(C_STALL));
        cyc();
        MemRead_EX = 1'b0; rd_EX = 5'd0;
        dmem_req_MEM = 1'b1; dmem_ready = 1'b0;
        #1 chk("mw_freeze1", 32'(ctrl), 32'(C_FREEZE));
        cyc();
        #1 chk("mw_freeze2", 32'(ctrl), 32'(C_FREEZE));
        cyc();
        #1 chk("mw_freeze3", 32'(ctrl), 32'(C_FREEZE));
        cyc();
        dmem_ready = 1'b1;
        #1 chk("mw_resume_stall", 32'(ctrl), 32'(C_STALL));
        cyc();
        dmem_req_MEM = 1'b0; dmem_ready = 1'b0;
        #1 chk("mw_flush", 32'(ctrl), 32'(C_FLUSH));
        cyc();
        clr();
        counters("mw", 2, 1, 3);

        // Saturation of flush_count
        do_reset();
        is_branch_ID = 1'b1; branch_taken_ID = 1'b1;
        for (int i = 0; i < 255; i++) cyc();
        chk("sat_at_max", 32'(flush_count), 32'hFF);
        #1 chk("sat_flush_ctrl", 32'(ctrl), 32'(C_FLUSH));
        cyc();
        chk("sat_hold", 32'(flush_count), 32'hFF);
        clr();

        // Async reset in MEMWAIT (resume=STALL)
        do_reset();
        branch_after_load();
        cyc();
        MemRead_EX = 1'b0; rd_EX = 5'd0;
        dmem_req_MEM = 1'b1;
        #1 chk("ar_freeze", 32'(ctrl), 32'(C_FREEZE));
        cyc();
        #2;
        rst = 1'b1;
        dmem_ready = 1'b1;
        #1;
        counters("ar_async", 0, 0, 0);
        // Back in RUN: a taken branch flushes rather than resuming a stall.
        chk("ar_run_flush", 32'(ctrl), 32'(C_FLUSH));
        cyc();
        rst = 1'b0;
        clr();
        #1 chk("ar_idle", 32'(ctrl), 32'(C_NONE));
        cyc();
        counters("ar_after", 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
